// File: rtl/arriskv_pkg.sv
// arriskv_pkg
//   Shared types for the ARRISKV decode stage.
//   instr_t      : decoded RV32I instruction enumeration (OP_NOP marks illegal).
//   instr_type_t : instruction format / class of a decoded op.
package arriskv_pkg;

  typedef enum logic [5:0] {
    OP_NOP,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
    OP_SB, OP_SH, OP_SW,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI,
    OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND
  } instr_t;

  typedef enum logic [3:0] {
    TYPE_NONE,  // illegal / unsupported encoding
    TYPE_R,     // register-register ALU
    TYPE_I,     // register-immediate ALU
    TYPE_IL,    // load
    TYPE_IS,    // store
    TYPE_IJ,    // JALR
    TYPE_B,     // conditional branch
    TYPE_U,     // LUI / AUIPC
    TYPE_J      // JAL
  } instr_type_t;

endpackage

// File: rtl/arriskv_decode_stage_if.sv
// arriskv_decode_stage_if
//   Bundles the instruction-in and decoded-op-out handshakes of the decode stage.
//   master : upstream fetch / downstream consumer side (drives in_*, flush, out_ready).
//   slave  : the decode stage itself (drives in_ready and all out_* fields).
interface arriskv_decode_stage_if #(
  parameter int XLEN = 32
);

  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [XLEN-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  arriskv_pkg::instr_t      out_op;
  arriskv_pkg::instr_type_t out_type;
  logic [4:0]               out_rs1;
  logic [4:0]               out_rs2;
  logic [4:0]               out_rd;
  logic [XLEN-1:0]          out_imm;
  logic [XLEN-1:0]          out_pc;
  logic                     out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_op, out_type, out_rs1, out_rs2, out_rd,
           out_imm, out_pc, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_op, out_type, out_rs1, out_rs2, out_rd,
           out_imm, out_pc, out_illegal
  );

endinterface

// File: rtl/arriskv_decode_stage.sv
// arriskv_decode_stage
//   Combinational RV32I decoder feeding a DEPTH-entry FIFO of decoded ops.
//   Ports:
//     clk  : clock, all state on rising edge
//     rst  : asynchronous active-high reset
//     bus  : slave side of arriskv_decode_stage_if
//            (flush, in_valid/in_ready/in_instr/in_pc, out_valid/out_ready,
//             out_op/out_type/out_rs1/out_rs2/out_rd/out_imm/out_pc/out_illegal)
module arriskv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input logic                   clk,
  input logic                   rst,
  arriskv_decode_stage_if.slave bus
);
  import arriskv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    instr_t          op;
    instr_type_t     ty;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic            illegal;
  } entry_t;

  // ---------------------------------------------------------------- decode
  logic [31:0]     instr;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;
  entry_t          dec;

  assign instr  = bus.in_instr;
  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  // Signed casts sign-extend bit 31 out to XLEN.
  assign imm_i  = XLEN'($signed(instr[31:20]));
  assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
  assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
  assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
  assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
  assign imm_sh = XLEN'(instr[24:20]);

  always_comb begin
    dec     = '0;
    dec.op  = OP_NOP;
    dec.ty  = TYPE_NONE;
    dec.pc  = bus.in_pc;
    case (opcode)
      7'b0110111: begin dec.op = OP_LUI;   dec.ty = TYPE_U; end
      7'b0010111: begin dec.op = OP_AUIPC; dec.ty = TYPE_U; end
      7'b1101111: begin dec.op = OP_JAL;   dec.ty = TYPE_J; end
      7'b1100111: begin
        dec.ty = TYPE_IJ;
        if (f3 == 3'b000) dec.op = OP_JALR;
      end
      7'b1100011: begin
        dec.ty = TYPE_B;
        case (f3)
          3'b000:  dec.op = OP_BEQ;
          3'b001:  dec.op = OP_BNE;
          3'b100:  dec.op = OP_BLT;
          3'b101:  dec.op = OP_BGE;
          3'b110:  dec.op = OP_BLTU;
          3'b111:  dec.op = OP_BGEU;
          default: dec.op = OP_NOP;
        endcase
      end
      7'b0000011: begin
        dec.ty = TYPE_IL;
        case (f3)
          3'b000:  dec.op = OP_LB;
          3'b001:  dec.op = OP_LH;
          3'b010:  dec.op = OP_LW;
          3'b100:  dec.op = OP_LBU;
          3'b101:  dec.op = OP_LHU;
          default: dec.op = OP_NOP;
        endcase
      end
      7'b0100011: begin
        dec.ty = TYPE_IS;
        case (f3)
          3'b000:  dec.op = OP_SB;
          3'b001:  dec.op = OP_SH;
          3'b010:  dec.op = OP_SW;
          default: dec.op = OP_NOP;
        endcase
      end
      7'b0010011: begin
        dec.ty = TYPE_I;
        case (f3)
          3'b000: dec.op = OP_ADDI;
          3'b010: dec.op = OP_SLTI;
          3'b011: dec.op = OP_SLTIU;
          3'b100: dec.op = OP_XORI;
          3'b110: dec.op = OP_ORI;
          3'b111: dec.op = OP_ANDI;
          3'b001: dec.op = (f7 == 7'h00) ? OP_SLLI : OP_NOP;
          default: begin
            if (f7 == 7'h00)      dec.op = OP_SRLI;
            else if (f7 == 7'h20) dec.op = OP_SRAI;
          end
        endcase
      end
      7'b0110011: begin
        dec.ty = TYPE_R;
        case ({f7, f3})
          {7'h00, 3'b000}: dec.op = OP_ADD;
          {7'h20, 3'b000}: dec.op = OP_SUB;
          {7'h00, 3'b001}: dec.op = OP_SLL;
          {7'h00, 3'b010}: dec.op = OP_SLT;
          {7'h00, 3'b011}: dec.op = OP_SLTU;
          {7'h00, 3'b100}: dec.op = OP_XOR;
          {7'h00, 3'b101}: dec.op = OP_SRL;
          {7'h20, 3'b101}: dec.op = OP_SRA;
          {7'h00, 3'b110}: dec.op = OP_OR;
          {7'h00, 3'b111}: dec.op = OP_AND;
          default:         dec.op = OP_NOP;
        endcase
      end
      default: dec.op = OP_NOP;
    endcase

    // Any encoding that did not resolve to a real op is illegal; its
    // register/immediate fields are zeroed so the consumer sees a clean NOP.
    if (dec.op == OP_NOP) dec.ty = TYPE_NONE;
    dec.illegal = (dec.op == OP_NOP);

    dec.rd  = instr[11:7];
    dec.rs1 = instr[19:15];
    dec.rs2 = instr[24:20];
    case (dec.ty)
      TYPE_R:  dec.imm = '0;
      TYPE_I, TYPE_IL, TYPE_IJ: begin
        dec.rs2 = '0;
        dec.imm = (dec.op == OP_SLLI || dec.op == OP_SRLI || dec.op == OP_SRAI)
                  ? imm_sh : imm_i;
      end
      TYPE_IS: begin dec.rd = '0; dec.imm = imm_s; end
      TYPE_B:  begin dec.rd = '0; dec.imm = imm_b; end
      TYPE_U:  begin dec.rs1 = '0; dec.rs2 = '0; dec.imm = imm_u; end
      TYPE_J:  begin dec.rs1 = '0; dec.rs2 = '0; dec.imm = imm_j; end
      default: begin dec.rd = '0; dec.rs1 = '0; dec.rs2 = '0; dec.imm = '0; end
    endcase
  end

  // ------------------------------------------------------------------ FIFO
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [PW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic            ready_reg;   // low during reset, high from the first edge after
  logic            full, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full          = (count_reg == CW'(DEPTH));
  assign bus.in_ready  = ready_reg && !full;
  assign bus.out_valid = (count_reg != '0);
  // Readiness comes only from fullness, so a pop never frees room for a
  // same-cycle push into a full FIFO. Flush suppresses both sides.
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      ready_reg <= 1'b1;
      if (bus.flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
        if (pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
        case ({push, pop})
          2'b10:   count_reg <= count_reg + 1'b1;
          2'b01:   count_reg <= count_reg - 1'b1;
          default: count_reg <= count_reg;
        endcase
      end
    end
  end

  // Storage carries no reset; stale contents are masked by count_reg.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= dec;
  end

  // Head is read combinationally so a push into an empty FIFO is visible
  // on the very next cycle; the slot cannot be rewritten while it is head.
  assign head            = mem[rd_ptr_reg];
  assign bus.out_op      = head.op;
  assign bus.out_type    = head.ty;
  assign bus.out_rs1     = head.rs1;
  assign bus.out_rs2     = head.rs2;
  assign bus.out_rd      = head.rd;
  assign bus.out_imm     = head.imm;
  assign bus.out_pc      = head.pc;
  assign bus.out_illegal = head.illegal;

endmodule

// File: tb/tb_arriskv_decode_stage.sv
// tb_arriskv_decode_stage
//   Directed checks of the decode stage: decode vectors, FIFO order,
//   back-pressure, flush and asynchronous reset.
module tb_arriskv_decode_stage;
  import arriskv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arriskv_decode_stage_if #(.XLEN(32)) bus ();

  arriskv_decode_stage #(.XLEN(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc    = pc;
  endtask

  task automatic check_head(input string tag, input instr_t op, input instr_type_t ty,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] imm, input logic [31:0] pc, input logic ill);
    check({tag, ".valid"},   32'(bus.out_valid),   32'd1);
    check({tag, ".op"},      32'(bus.out_op),      32'(op));
    check({tag, ".type"},    32'(bus.out_type),    32'(ty));
    check({tag, ".rd"},      32'(bus.out_rd),      32'(rd));
    check({tag, ".rs1"},     32'(bus.out_rs1),     32'(rs1));
    check({tag, ".rs2"},     32'(bus.out_rs2),     32'(rs2));
    check({tag, ".imm"},     bus.out_imm,          imm);
    check({tag, ".pc"},      bus.out_pc,           pc);
    check({tag, ".illegal"}, 32'(bus.out_illegal), 32'(ill));
  endtask

  // Push one instruction into the empty FIFO, check it one cycle later, pop it.
  task automatic run_vec(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input instr_t op, input instr_type_t ty,
                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] imm, input logic ill);
    drive(1'b1, ins, pc);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check_head(tag, op, ty, rd, rs1, rs2, imm, pc, ill);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, ".drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0);

    // Reset state
    #12;
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.in_ready",  32'(bus.in_ready),  32'd0);
    step();
    rst = 1'b0;
    check("rel.in_ready_before_edge", 32'(bus.in_ready), 32'd0);
    step();
    check("rel.in_ready", 32'(bus.in_ready), 32'd1);

    // Single-op decode vectors
    run_vec("addi",    32'hFFF00093, 32'h100, OP_ADDI, TYPE_I,  5'd1, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b0);
    run_vec("sw",      32'h0020A223, 32'h104, OP_SW,   TYPE_IS, 5'd0, 5'd1, 5'd2, 32'h4,        1'b0);
    run_vec("srai",    32'h4030D113, 32'h108, OP_SRAI, TYPE_I,  5'd2, 5'd1, 5'd0, 32'h3,        1'b0);
    run_vec("sub",     32'h402081B3, 32'h10C, OP_SUB,  TYPE_R,  5'd3, 5'd1, 5'd2, 32'h0,        1'b0);
    run_vec("jal",     32'h008000EF, 32'h110, OP_JAL,  TYPE_J,  5'd1, 5'd0, 5'd0, 32'h8,        1'b0);
    run_vec("illegal", 32'hFFFFFFFF, 32'h114, OP_NOP,  TYPE_NONE, 5'd0, 5'd0, 5'd0, 32'h0,      1'b1);
    run_vec("badf7",   32'h022081B3, 32'h118, OP_NOP,  TYPE_NONE, 5'd0, 5'd0, 5'd0, 32'h0,      1'b1);

    // BEQ then LUI, kept in order
    drive(1'b1, 32'hFE000EE3, 32'h200);
    step();
    drive(1'b1, 32'h123452B7, 32'h204);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("order.in_ready_full", 32'(bus.in_ready), 32'd0);
    check_head("order.beq", OP_BEQ, TYPE_B, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFC, 32'h200, 1'b0);
    bus.out_ready = 1'b1;
    step();
    check_head("order.lui", OP_LUI, TYPE_U, 5'd5, 5'd0, 5'd0, 32'h12345000, 32'h204, 1'b0);
    step();
    check("order.empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Back-pressure: three pushes attempted, only two accepted
    drive(1'b1, 32'h00700193, 32'h300);
    step();
    drive(1'b1, 32'h00800213, 32'h304);
    step();
    check("bp.in_ready_after2", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'h00900293, 32'h308);
    step();
    check("bp.head_pc",   bus.out_pc,  32'h300);
    check("bp.head_imm",  bus.out_imm, 32'h7);
    step();
    check("bp.head_pc_stable", bus.out_pc, 32'h300);
    // Pop while full with in_valid still high: no same-cycle push
    bus.out_ready = 1'b1;
    check("bp.in_ready_full_pop", 32'(bus.in_ready), 32'd0);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("bp.second_pc",  bus.out_pc,  32'h304);
    check("bp.second_imm", bus.out_imm, 32'h8);
    step();
    check("bp.third_never", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Simultaneous push and pop with one entry
    drive(1'b1, 32'h00700193, 32'h400);
    step();
    drive(1'b1, 32'h00800213, 32'h404);
    bus.out_ready = 1'b1;
    step();
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b0;
    check("pp.valid",    32'(bus.out_valid), 32'd1);
    check("pp.pc",       bus.out_pc,         32'h404);
    check("pp.in_ready", 32'(bus.in_ready),  32'd1);
    bus.out_ready = 1'b1;
    step();
    check("pp.empty", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Flush with FIFO full and in_valid high
    drive(1'b1, 32'h00700193, 32'h500);
    step();
    drive(1'b1, 32'h00800213, 32'h504);
    step();
    check("flush.full", 32'(bus.in_ready), 32'd0);
    drive(1'b1, 32'hFFF00093, 32'h508);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush.in_ready",  32'(bus.in_ready),  32'd1);
    step();
    check("flush.no_incoming", 32'(bus.out_valid), 32'd0);

    // Flush while not full with an accepted-looking handshake
    drive(1'b1, 32'h00700193, 32'h600);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    check("flush2.out_valid", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 32'h00700193, 32'h700);
    step();
    drive(1'b0, 32'h0, 32'h0);
    check("flush2.resume_pc", bus.out_pc, 32'h700);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Asynchronous reset mid-stream
    drive(1'b1, 32'h00700193, 32'h800);
    step();
    drive(1'b1, 32'h00800213, 32'h804);
    step();
    drive(1'b0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("arst.out_valid", 32'(bus.out_valid), 32'd0);
    check("arst.in_ready",  32'(bus.in_ready),  32'd0);
    step();
    step();
    rst = 1'b0;
    check("arst.rel_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("arst.in_ready_up", 32'(bus.in_ready),  32'd1);
    check("arst.no_stale",    32'(bus.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/arriskv_decode_stage.md
ARRISKV_DECODE_STAGE -- requirements
Module: arriskv_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32: width of the sign-extended immediate and PC fields.
REQ-002 The block SHALL have parameter DEPTH, default 2: number of decoded-op output buffer entries, power of two, at least 1.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 The block SHALL have the following ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-high reset.
- flush  in  1  discard all buffered and incoming ops.
- in_valid  in  1  instruction word present.
- in_ready  out  1  block can accept an instruction.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  XLEN  PC of in_instr.
- out_valid  out  1  decoded op present.
- out_ready  in  1  consumer accepts the op.
- out_op  out  instr_t  decoded instruction enumeration from the package.
- out_type  out  instr_type_t  instruction type from the package.
- out_rs1, out_rs2, out_rd  out  5 each  register indices.
- out_imm  out  XLEN  immediate, sign-extended to XLEN.
- out_pc  out  XLEN  PC carried with the op.
- out_illegal  out  1  instruction not in the supported set.

Function
REQ-005 Transfers SHALL occur only on valid&ready at a clock edge, on each side.
REQ-006 Decode SHALL be combinational on in_instr; the result SHALL be written into a DEPTH-entry FIFO on input handshake.
REQ-007 Latency SHALL be 1 cycle: an instruction accepted into an empty FIFO SHALL appear at the outputs with out_valid=1 in the next cycle.
REQ-008 in_ready SHALL equal not-full; when the FIFO is full, a same-cycle pop SHALL NOT enable a same-cycle push.
REQ-009 When the FIFO is not full, a simultaneous push and pop SHALL leave the occupancy unchanged and keep FIFO order.
REQ-010 out_valid SHALL equal not-empty; output fields SHALL show the head entry and SHALL stay stable while out_valid=1 and out_ready=0.
REQ-011 Read and write pointers SHALL wrap modulo DEPTH, and a count of width clog2(DEPTH)+1 SHALL track occupancy.
REQ-012 Immediate extraction SHALL follow RV32I I/S/B/U/J formats and SHALL sign-extend bit 31 to XLEN:
- U-type imm = {instr[31:12], 12'b0}.
- B-type and J-type imm bit 0 = 0.
REQ-013 For S and B types out_rd SHALL be 0; for U, J and I types out_rs2 SHALL be 0; for U and J types out_rs1 SHALL be 0.
REQ-014 Shift immediates (SLLI/SRLI/SRAI) SHALL give out_imm = {0, instr[24:20]}, with SRAI selected by instr[30].
REQ-015 Types SHALL map as follows: loads IL, stores IS, JALR IJ, JAL J, branches B, LUI/AUIPC U, OP R, OP-IMM I.
REQ-016 For an unsupported opcode, funct3 or funct7 combination, the block SHALL set out_op=NOP and out_illegal=1, and SHALL buffer the entry in order.
REQ-017 On a flush edge, count and pointers SHALL reset to 0, and any input handshaking in the same cycle SHALL be discarded.
REQ-018 in_ready SHALL be 1 in the cycle after a flush.
REQ-019 Flush SHALL take priority over push and pop.

Reset
REQ-020 While rst=1 the block SHALL drive out_valid=0, clear count and pointers, and drive in_ready=0.
REQ-021 After rst deasserts, in_ready SHALL go to 1 on the first clock edge.
REQ-022 Reset SHALL abandon any in-flight op, and FIFO data contents SHALL be don't-care.

Verification
REQ-023 The bench SHALL cover: 0xFFF00093 (ADDI x1,x0,-1) accepted into an empty FIFO -> next cycle out_op=ADDI, out_type=I, out_rd=1, out_rs1=0, out_imm=0xFFFFFFFF.
REQ-024 The bench SHALL cover: 0x0020A223 (SW x2,4(x1)) -> out_op=SW, out_type=IS, out_rs1=1, out_rs2=2, out_rd=0, out_imm=4.
REQ-025 The bench SHALL cover: 0xFE000EE3 (BEQ x0,x0,-4), then 0x123452B7 (LUI x5,0x12345) -> BEQ with out_imm=0xFFFFFFFC, then LUI with out_rd=5, out_imm=0x12345000, in order.
REQ-026 The bench SHALL cover: out_ready=0 and 3 pushes attempted with DEPTH=2 -> in_ready=0 after 2, head unchanged; raising out_ready drains in order.
REQ-027 The bench SHALL cover: 0xFFFFFFFF input -> out_op=NOP, out_illegal=1.
REQ-028 The bench SHALL cover: flush with the FIFO full and in_valid=1 -> out_valid=0 next cycle, incoming op never appears.
REQ-029 The bench SHALL cover: rst asserted mid-stream -> out_valid=0 immediately (asynchronously), no stale op after release.
